fp_issue_ctrl: RTL and testbench
================================

// Module: fp_issue_ctrl
// PURPOSE
//  Credit-based issue/retire controller placed directly upstream of one pipelined FP core (fadd/fsub/fmul/fdiv).
//  Accepts operand pairs on a valid/ready port and drives the core's go/pipeEn inputs.
//  Captures every core result (on rdy) into a local result FIFO; emits results in order on a valid/ready port.
//  Issue is gated by credits, so a result never arrives to a full FIFO and pipeEn never has to stall.
// PARAMETERS
//  WIDTH    32  operand/result width
//  LATENCY  8   max core cycles from go to rdy (pipeEn held high); sizes the post-reset warm-up
//  DEPTH    16  result FIFO entries, power of two, >=2
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      operand pair accepted when in_valid&in_ready
//  in_a       in   WIDTH  operand a
//  in_b       in   WIDTH  operand b
//  op_a       out  WIDTH  to core a (= in_a)
//  op_b       out  WIDTH  to core b (= in_b)
//  op_go      out  1      to core go (= in_valid&in_ready)
//  op_pipeEn  out  1      to core pipeEn
//  op_result  in   WIDTH  from core result
//  op_rdy     in   1      from core rdy/done
//  out_valid  out  1      result FIFO non-empty
//  out_ready  in   1      downstream pops when out_valid&out_ready
//  out_data   out  WIDTH  FIFO head (first-word fall-through)
//  flush_req  in   1      level; stop accepting and drain
//  flush_done out  1      1-cycle pulse: inflight==0 and FIFO empty after flush
//  err        out  1      sticky: op_rdy seen with inflight==0 outside WARM
// BEHAVIOUR
//  Reset (async, rst_n=0): state=WARM, warm_cnt=0, inflight=0, FIFO empty, in_ready=0, out_valid=0,
//   op_go=0, op_pipeEn=0, flush_done=0, err=0. op_pipeEn=1 in every state after reset release.
//  States:
//   WARM:  count LATENCY+2 cycles; op_rdy ignored (drains stale core results, no err) -> RUN.
//   RUN:   in_ready = (fifo_cnt + inflight) < DEPTH; flush_req=1 -> DRAIN.
//   DRAIN: in_ready=0; when inflight==0 && fifo empty -> flush_done=1 for 1 cycle, -> RUN
//          (flush_req still high stays in DRAIN, pulse not repeated).
//  inflight (clog2(DEPTH+1) bits): +1 on op_go, -1 on op_rdy, unchanged on both.
//  FIFO push on op_rdy (outside WARM) when inflight!=0, pop on out_valid&out_ready; simultaneous push+pop
//   in the same cycle leaves fifo_cnt unchanged. Pointers wrap mod DEPTH.
//  Invariant: fifo_cnt + inflight <= DEPTH always; push to full FIFO impossible by construction.
//  op_rdy with inflight==0 outside WARM: result dropped, err<=1 (cleared only by reset).
//  Latency: input to out_valid = core latency + 1 cycle (FIFO write); zero-bubble at full throughput
//   if downstream ready.
//  Reset mid-operation: all queued and in-flight results discarded; WARM absorbs core outputs.
// CONFIGURATION
//  FP_ISSUE_STATS_EN defined: adds outputs stat_issued[31:0], stat_retired[31:0] (wrap mod 2^32,
//   reset 0; +1 per op_go / per FIFO pop) and stat_stall[31:0] (+1 each RUN cycle with
//   in_valid&!in_ready).
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset, op_rdy pulse in WARM cycle 3 -> err=0, FIFO empty, in_ready rises cycle LATENCY+2.
//  20 back-to-back pairs, model core LATENCY=8, out_ready=1 -> 20 results in order, first at issue+9.
//  out_ready=0, 20 pairs offered -> exactly 16 accepted, in_ready=0, fifo_cnt+inflight==16; release ->
//   remaining 4 accepted.
//  Same-cycle push+pop at fifo_cnt=16-1 -> fifo_cnt unchanged, no loss, order kept.
//  flush_req with 3 in flight -> in_ready=0, flush_done exactly once after 3rd result popped.
//  Spurious op_rdy in RUN with inflight=0 -> err=1 sticky, FIFO unchanged; STATS build: issued==retired.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// Credit-based issue/retire controller in front of a pipelined FP core, with an in-order result FIFO.
// Optional FP_ISSUE_STATS_EN adds stat_issued / stat_retired / stat_stall counters.
module fp_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 8,
    parameter int DEPTH   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_go,
    output logic             op_pipeEn,
    input  logic [WIDTH-1:0] op_result,
    input  logic             op_rdy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush_req,
    output logic             flush_done,
    output logic             err,
`ifdef FP_ISSUE_STATS_EN
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_retired,
    output logic [31:0]      stat_stall,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {S_WARM, S_RUN, S_DRAIN} state_t;

    state_t           r_state, w_next;
    logic [WW-1:0]    r_warm_cnt;
    logic [CW-1:0]    r_inflight, r_fifo_cnt;
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_pipe_en, r_err, r_flushed;
    logic             w_in_ready, w_go, w_rdy_live, w_push, w_spur, w_pop;
    logic             w_room, w_idle, w_flush_done;
    logic [CW:0]      w_occupancy;

    // Both ports use valid/ready: a transfer happens in any cycle where valid and ready are both high.
    // Credits: a slot is reserved for every issued op, so a returning result always finds FIFO space.
    assign w_occupancy = {1'b0, r_fifo_cnt} + {1'b0, r_inflight};
    assign w_room      = w_occupancy < (CW+1)'(DEPTH);
    assign w_go        = in_valid & w_in_ready;
    assign w_rdy_live  = op_rdy && (r_state != S_WARM);
    assign w_push      = w_rdy_live && (r_inflight != '0);
    assign w_spur      = w_rdy_live && (r_inflight == '0);
    assign w_pop       = out_valid & out_ready;
    assign w_idle      = (r_inflight == '0) && (r_fifo_cnt == '0);

    assign in_ready   = w_in_ready;
    assign op_a       = in_a;
    assign op_b       = in_b;
    assign op_go      = w_go;
    assign op_pipeEn  = r_pipe_en;
    assign out_valid  = (r_fifo_cnt != '0);
    assign out_data   = r_mem[r_rd_ptr];
    assign flush_done = w_flush_done;
    assign err        = r_err;
    assign dbg_state  = r_state;

    always_comb begin
        w_next       = r_state;
        w_in_ready   = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            S_WARM: if (r_warm_cnt == WW'(LATENCY + 1)) w_next = S_RUN;
            S_RUN: begin
                if (flush_req) w_next = S_DRAIN;
                else           w_in_ready = w_room;
            end
            S_DRAIN: begin
                // r_flushed keeps a held flush_req from re-pulsing flush_done.
                if (w_idle) begin
                    w_flush_done = !r_flushed;
                    if (!flush_req) w_next = S_RUN;
                end
            end
            default: w_next = S_WARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WARM;
            r_warm_cnt <= '0;
            r_pipe_en  <= 1'b0;
            r_err      <= 1'b0;
            r_flushed  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pipe_en <= 1'b1;
            if (r_state == S_WARM) r_warm_cnt <= r_warm_cnt + WW'(1);
            if (w_spur) r_err <= 1'b1;
            if (w_next != S_DRAIN) r_flushed <= 1'b0;
            else if (w_flush_done) r_flushed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case ({w_go, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= op_result;
    end

`ifdef FP_ISSUE_STATS_EN
    logic [31:0] r_stat_issued, r_stat_retired, r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_issued  <= '0;
            r_stat_retired <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_go)  r_stat_issued  <= r_stat_issued + 32'd1;
            if (w_pop) r_stat_retired <= r_stat_retired + 32'd1;
            if ((r_state == S_RUN) && in_valid && !w_in_ready) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_issued  = r_stat_issued;
    assign stat_retired = r_stat_retired;
    assign stat_stall   = r_stat_stall;
`endif

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: an 8-stage adder models the FP core; a queue scoreboard checks result order.
module tb_fp_issue_ctrl;
  localparam int W   = 32;
  localparam int LAT = 8;
  localparam int DEP = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, op_go, op_pipeEn, op_rdy;
  logic [W-1:0] in_a, in_b, op_a, op_b, op_result, out_data;
  logic         out_valid, out_ready, flush_req, flush_done, err;
  logic [1:0]   dbg_state;
`ifdef FP_ISSUE_STATS_EN
  logic [31:0]  stat_issued, stat_retired, stat_stall;
`endif

  logic                   inj_rdy;
  logic [W-1:0]           inj_val;
  logic [LAT-1:0][W:0]    core_pipe;

  logic [W-1:0] exp_q[$];
  vec_t         vec[20];
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_pops   = 0;
  int n_acc    = 0;
  int last_pop_cyc, first_out_cyc, first_go_cyc;
  bit seen_out, seen_go;

  fp_issue_ctrl #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .op_a(op_a), .op_b(op_b), .op_go(op_go), .op_pipeEn(op_pipeEn),
    .op_result(op_result), .op_rdy(op_rdy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush_req(flush_req), .flush_done(flush_done), .err(err),
`ifdef FP_ISSUE_STATS_EN
    .stat_issued(stat_issued), .stat_retired(stat_retired), .stat_stall(stat_stall),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // core model: fixed LATENCY-cycle adder, advancing only while pipeEn is high
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) core_pipe <= '0;
    else if (op_pipeEn) core_pipe <= {core_pipe[LAT-2:0], {op_go, op_a + op_b}};
  end
  assign op_rdy    = core_pipe[LAT-1][W] | inj_rdy;
  assign op_result = inj_rdy ? inj_val : core_pipe[LAT-1][W-1:0];

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (rst_n) begin
      if (in_valid && in_ready) n_acc++;
      if (out_valid && !seen_out) begin
        seen_out = 1'b1;
        first_out_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got %h want no output", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL out_data: got %h want %h", out_data, e);
          end
        end
        n_pops++;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver: holds one pair on the input until accepted or the budget runs out
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp,
                      input int max_cyc, output bit ok, output int acc_cyc);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    ok = 1'b0;
    acc_cyc = -1;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        ok = 1'b1;
        acc_cyc = cyc;
        if (!seen_go) begin
          seen_go = 1'b1;
          first_go_cyc = cyc;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      tick(1);
      c++;
    end
    tick(1);
    check(name, exp_q.size(), 0);
  endtask

  task automatic fill_vec();
    for (int i = 0; i < 20; i++) begin
      vec[i].a = $urandom;
      vec[i].b = $urandom_range(0, 100000);
    end
    vec[0].a = '0;
    vec[0].b = '0;
    vec[1].a = 32'hffff_ffff;
    vec[1].b = 32'd1;
    for (int i = 0; i < 20; i++) vec[i].exp = vec[i].a + vec[i].b;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int  rise, idx, pops0, first_acc, last_acc, acc_c, done_cnt, done_cyc, acc_drain;
    bit  ok, found;
    in_valid = 0; in_a = '0; in_b = '0; out_ready = 0; flush_req = 0;
    inj_rdy = 0; inj_val = '0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_go", op_go, 0);
    check("rst_pipeEn", op_pipeEn, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_err", err, 0);

    // warm-up with a stale op_rdy in cycle 3
    rst_n = 1'b1;
    rise = -1;
    for (int k = 0; k < 30; k++) begin
      inj_rdy = (k == 3);
      inj_val = 32'hdead_beef;
      @(negedge clk);
      if (in_ready && rise < 0) rise = k;
      @(posedge clk);
      #1;
      if (rise >= 0) break;
    end
    inj_rdy = 0;
    check("warm_ready_cycle", rise, LAT + 2);
    check("warm_err", err, 0);
    check("warm_fifo_empty", out_valid, 0);
    check("warm_pipeEn", op_pipeEn, 1);

    // table: 20 back-to-back pairs, downstream always ready
    fill_vec();
    out_ready = 1;
    seen_go = 0;
    seen_out = 0;
    pops0 = n_pops;
    idx = 0;
    first_acc = -1;
    last_acc = -1;
    for (int i = 0; i < 20; i++) begin
      send(vec[i].a, vec[i].b, vec[i].exp, 50, ok, acc_c);
      if (ok) idx++;
      if (i == 0) first_acc = acc_c;
      last_acc = acc_c;
    end
    in_valid = 0;
    check("t1_accepted", idx, 20);
    check("t1_back_to_back", last_acc - first_acc, 19);
    wait_drain("t1_drain");
    check("t1_pops", n_pops - pops0, 20);
    check("t1_first_latency", first_out_cyc - first_go_cyc, LAT + 1);

    // backpressure: only DEPTH credits available
    fill_vec();
    out_ready = 0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 20; c++) begin
      in_valid = 1; in_a = vec[idx].a; in_b = vec[idx].b;
      @(negedge clk);
      if (in_ready) begin exp_q.push_back(vec[idx].exp); idx++; end
      @(posedge clk);
      #1;
    end
    check("t3_accepted", idx, DEP);
    check("t3_in_ready", in_ready, 0);
    check("t3_occupancy", dut.r_fifo_cnt + dut.r_inflight, DEP);
    check("t3_out_valid", out_valid, 1);
    out_ready = 1;
    for (int c = 0; c < 60 && idx < 20; c++) begin
      in_valid = 1; in_a = vec[idx].a; in_b = vec[idx].b;
      @(negedge clk);
      if (in_ready) begin exp_q.push_back(vec[idx].exp); idx++; end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    check("t3_remaining", idx, 20);
    wait_drain("t3_drain");

    // push and pop in the same cycle with DEPTH-1 entries queued
    fill_vec();
    out_ready = 0;
    idx = 0;
    for (int c = 0; c < 60 && idx < DEP - 1; c++) begin
      in_valid = 1; in_a = vec[idx].a; in_b = vec[idx].b;
      @(negedge clk);
      if (in_ready) begin exp_q.push_back(vec[idx].exp); idx++; end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    for (int c = 0; c < 20 && dut.r_inflight != 0; c++) tick(1);
    check("t4_fill", dut.r_fifo_cnt, DEP - 1);
    send(vec[19].a, vec[19].b, vec[19].exp, 10, ok, acc_c);
    in_valid = 0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (op_rdy) begin found = 1; break; end
      tick(1);
    end
    check("t4_rdy_seen", found, 1);
    out_ready = 1;
    check("t4_cnt_before", dut.r_fifo_cnt, DEP - 1);
    tick(1);
    out_ready = 0;
    check("t4_cnt_after", dut.r_fifo_cnt, DEP - 1);
    out_ready = 1;
    wait_drain("t4_drain");

    // flush with three operations in flight
    pops0 = n_pops;
    for (int i = 0; i < 3; i++) send(vec[i].a, vec[i].b, vec[i].exp, 20, ok, acc_c);
    in_valid = 0;
    flush_req = 1;
    done_cnt = 0;
    done_cyc = -1;
    acc_drain = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (c > 0);
      in_a = vec[5].a;
      in_b = vec[5].b;
      @(negedge clk);
      if (flush_done) begin done_cnt++; done_cyc = cyc; end
      if (in_valid && in_ready) acc_drain++;
      @(posedge clk);
      #1;
    end
    check("t5_no_accept", acc_drain, 0);
    check("t5_pops", n_pops - pops0, 3);
    check("t5_done_count", done_cnt, 1);
    check("t5_done_after_last_pop", done_cyc, last_pop_cyc + 1);
    flush_req = 0;
    in_valid = 0;
    tick(1);
    check("t5_back_to_run", in_ready, 1);

    // spurious op_rdy with nothing in flight
    tick(2);
    inj_val = 32'h0000_1234;
    inj_rdy = 1;
    tick(1);
    inj_rdy = 0;
    check("t6_err", err, 1);
    check("t6_fifo_empty", out_valid, 0);
    tick(5);
    check("t6_err_sticky", err, 1);
    check("t6_fifo_still_empty", out_valid, 0);
`ifdef FP_ISSUE_STATS_EN
    check("t6_stat_issued", stat_issued, n_acc);
    check("t6_stat_retired", stat_retired, n_pops);
    check("t6_issued_eq_retired", stat_issued, stat_retired);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
